// File: rtl/wts_adsr_envelope_multi.sv
// Time-multiplexed N-channel ADSR envelope generator, one slot per active pulse.
// Per-channel level/state/rate counter in arrays; key events latched until visited.
//
// Ports:
//   clk, nreset          clock, async active-low reset
//   active               slot strobe; one channel processed per pulse
//   key_on/release/off   per-channel key pulses (NUM_CH bits)
//   reg_ar/dr/sr/rr      packed per-channel rates (NUM_CH*RW), ch0 in LSBs
//   reg_sl               packed sustain levels (NUM_CH*(LW-1))
//   envelope             packed per-channel level 0..2^(LW-1), registered
//   busy                 per-channel state != IDLE, registered
module wts_adsr_envelope_multi #(
  parameter int NUM_CH = 5,
  parameter int LW     = 8,
  parameter int RW     = 8,
  parameter int PRE    = 8
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       active,
  input  logic [NUM_CH-1:0]          key_on,
  input  logic [NUM_CH-1:0]          key_release,
  input  logic [NUM_CH-1:0]          key_off,
  input  logic [NUM_CH*RW-1:0]       reg_ar,
  input  logic [NUM_CH*RW-1:0]       reg_dr,
  input  logic [NUM_CH*RW-1:0]       reg_sr,
  input  logic [NUM_CH*RW-1:0]       reg_rr,
  input  logic [NUM_CH*(LW-1)-1:0]   reg_sl,
  output logic [NUM_CH*LW-1:0]       envelope,
  output logic [NUM_CH-1:0]          busy
);

  localparam int CW = RW + PRE;
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [LW-1:0] LMAX = LW'(1) << (LW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } st_t;

  st_t             st_q  [NUM_CH];
  logic [LW-1:0]   lvl_q [NUM_CH];
  logic [CW-1:0]   cnt_q [NUM_CH];

  logic [SW-1:0]     slot;
  logic [NUM_CH-1:0] pend_on;
  logic [NUM_CH-1:0] pend_rel;
  logic [NUM_CH-1:0] pend_off;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] clr;

  logic [LW-1:0]   cur_lvl;
  st_t             cur_st;
  logic [CW-1:0]   cur_cnt;
  logic [RW-1:0]   ar;
  logic [RW-1:0]   dr;
  logic [RW-1:0]   sr;
  logic [RW-1:0]   rr;
  logic [LW-2:0]   sl;
  logic            ev_on;
  logic            ev_rel;
  logic            ev_off;

  logic [RW-1:0]   rate;
  logic [LW-1:0]   stp_lvl;
  logic [LW-1:0]   nxt_lvl;
  st_t             nxt_st;
  logic [CW-1:0]   nxt_cnt;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      sel[i] = (slot == SW'(i));
    clr = active ? sel : '0;
  end

  // Gather the visited channel's context; a same-cycle pulse counts as pending.
  always_comb begin
    cur_lvl = '0;
    cur_st  = S_IDLE;
    cur_cnt = '0;
    ar      = '0;
    dr      = '0;
    sr      = '0;
    rr      = '0;
    sl      = '0;
    ev_on   = 1'b0;
    ev_rel  = 1'b0;
    ev_off  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel[i]) begin
        cur_lvl = lvl_q[i];
        cur_st  = st_q[i];
        cur_cnt = cnt_q[i];
        ar      = reg_ar[i*RW +: RW];
        dr      = reg_dr[i*RW +: RW];
        sr      = reg_sr[i*RW +: RW];
        rr      = reg_rr[i*RW +: RW];
        sl      = reg_sl[i*(LW-1) +: (LW-1)];
        ev_on   = pend_on[i]  | key_on[i];
        ev_rel  = pend_rel[i] | key_release[i];
        ev_off  = pend_off[i] | key_off[i];
      end
    end
  end

  always_comb begin
    rate = '0;
    unique case (cur_st)
      S_ATTACK:  rate = ar;
      S_DECAY:   rate = dr;
      S_SUSTAIN: rate = sr;
      S_RELEASE: rate = rr;
      default:   rate = '0;
    endcase

    stp_lvl = cur_lvl;
    nxt_lvl = cur_lvl;
    nxt_st  = cur_st;
    nxt_cnt = cur_cnt;

    if (ev_off) begin
      nxt_lvl = '0;
      nxt_st  = S_IDLE;
      nxt_cnt = '0;
    end else if (ev_on) begin
      nxt_st  = S_ATTACK;
      nxt_lvl = (ar == '0) ? LMAX : '0;
      nxt_cnt = {ar, {PRE{1'b1}}};
    end else if (ev_rel) begin
      if (cur_st != S_IDLE)
        nxt_st = S_RELEASE;
    end else begin
      if (cur_cnt != '0) begin
        nxt_cnt = cur_cnt - CW'(1);
      end else begin
        nxt_cnt = {rate, {PRE{1'b1}}};
        if (rate != '0) begin
          if (cur_st == S_ATTACK) begin
            if (cur_lvl < LMAX)
              stp_lvl = cur_lvl + LW'(1);
          end else if (cur_lvl != '0) begin
            stp_lvl = cur_lvl - LW'(1);
          end
        end
      end
      nxt_lvl = stp_lvl;
      // Transitions look at the post-step level of this same visit.
      unique case (cur_st)
        S_ATTACK: begin
          if (stp_lvl >= LMAX) begin
            nxt_lvl = LMAX;
            nxt_st  = S_DECAY;
          end
        end
        S_DECAY: begin
          if (stp_lvl <= {1'b0, sl})
            nxt_st = S_SUSTAIN;
        end
        S_SUSTAIN, S_RELEASE: begin
          if (stp_lvl == '0)
            nxt_st = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      slot     <= '0;
      pend_on  <= '0;
      pend_rel <= '0;
      pend_off <= '0;
      envelope <= '0;
      busy     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        lvl_q[i] <= '0;
        st_q[i]  <= S_IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      pend_on  <= (pend_on  | key_on)      & ~clr;
      pend_rel <= (pend_rel | key_release) & ~clr;
      pend_off <= (pend_off | key_off)     & ~clr;
      if (active) begin
        if (slot == SW'(NUM_CH - 1))
          slot <= '0;
        else
          slot <= slot + SW'(1);
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr[i]) begin
          lvl_q[i] <= nxt_lvl;
          st_q[i]  <= nxt_st;
          cnt_q[i] <= nxt_cnt;
        end
        envelope[i*LW +: LW] <= lvl_q[i];
        busy[i]              <= (st_q[i] != S_IDLE);
      end
    end
  end

endmodule

// File: tb/tb_wts_adsr_envelope_multi.sv
// Bench for wts_adsr_envelope_multi: event table plus timed ADSR,
// pending-latch and async-reset sequences (PRE=2 keeps step times short).
module tb_wts_adsr_envelope_multi;

  localparam int NUM_CH = 5;
  localparam int LW     = 8;
  localparam int RW     = 8;
  localparam int PRE    = 2;

  logic                     clk = 1'b0;
  logic                     nreset;
  logic                     active;
  logic [NUM_CH-1:0]        key_on;
  logic [NUM_CH-1:0]        key_release;
  logic [NUM_CH-1:0]        key_off;
  logic [NUM_CH*RW-1:0]     reg_ar;
  logic [NUM_CH*RW-1:0]     reg_dr;
  logic [NUM_CH*RW-1:0]     reg_sr;
  logic [NUM_CH*RW-1:0]     reg_rr;
  logic [NUM_CH*(LW-1)-1:0] reg_sl;
  logic [NUM_CH*LW-1:0]     envelope;
  logic [NUM_CH-1:0]        busy;

  wts_adsr_envelope_multi #(
    .NUM_CH(NUM_CH),
    .LW(LW),
    .RW(RW),
    .PRE(PRE)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .active(active),
    .key_on(key_on),
    .key_release(key_release),
    .key_off(key_off),
    .reg_ar(reg_ar),
    .reg_dr(reg_dr),
    .reg_sr(reg_sr),
    .reg_rr(reg_rr),
    .reg_sl(reg_sl),
    .envelope(envelope),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NUM_CH-1:0]    on;
    logic [NUM_CH-1:0]    rel;
    logic [NUM_CH-1:0]    off;
    int                   wait_n;
    logic [NUM_CH*LW-1:0] env;
    logic [NUM_CH-1:0]    bsy;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] on,
                       input logic [NUM_CH-1:0] rel,
                       input logic [NUM_CH-1:0] off);
    key_on      = on;
    key_release = rel;
    key_off     = off;
    tick(1);
    key_on      = '0;
    key_release = '0;
    key_off     = '0;
  endtask

  function automatic logic [7:0] get_lvl(input int ch);
    return envelope[ch*LW +: LW];
  endfunction

  initial begin
    bit hit;
    tbl[0] = '{5'b00100, 5'b00000, 5'b00000, 12, 40'h0000800000, 5'b00100};
    tbl[1] = '{5'b00000, 5'b00000, 5'b00000, 50, 40'h0000800000, 5'b00100};
    tbl[2] = '{5'b00010, 5'b00000, 5'b00010, 12, 40'h0000800000, 5'b00100};
    tbl[3] = '{5'b00000, 5'b00010, 5'b00000, 12, 40'h0000800000, 5'b00100};
    tbl[4] = '{5'b00000, 5'b00100, 5'b00000, 12, 40'h0000800000, 5'b00100};
    tbl[5] = '{5'b00000, 5'b00000, 5'b00100, 12, 40'h0000000000, 5'b00000};
    tbl[6] = '{5'b10001, 5'b00000, 5'b00000, 12, 40'h8000000080, 5'b10001};
    tbl[7] = '{5'b01000, 5'b00000, 5'b00001, 12, 40'h8080000000, 5'b11000};
    tbl[8] = '{5'b00000, 5'b00000, 5'b11111, 12, 40'h0000000000, 5'b00000};

    nreset      = 1'b0;
    active      = 1'b0;
    key_on      = '0;
    key_release = '0;
    key_off     = '0;
    reg_ar      = '0;
    reg_dr      = '0;
    reg_sr      = '0;
    reg_rr      = '0;
    reg_sl      = '0;
    tick(2);
    chk("reset env", 64'(envelope), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    nreset = 1'b1;
    active = 1'b1;
    reg_sl[2*(LW-1) +: (LW-1)] = 7'd64;
    tick(2);

    for (int i = 0; i < 9; i++) begin
      pulse(tbl[i].on, tbl[i].rel, tbl[i].off);
      tick(tbl[i].wait_n);
      chk($sformatf("vec%0d env", i), 64'(envelope), 64'(tbl[i].env));
      chk($sformatf("vec%0d busy", i), 64'(busy), 64'(tbl[i].bsy));
    end

    // ch0 attack/decay/sustain; m counts cycles from the key_on visit
    reg_ar[0 +: RW]      = 8'd1;
    reg_dr[0 +: RW]      = 8'd1;
    reg_sl[0 +: (LW-1)]  = 7'd100;
    pulse(5'b00001, 5'b00000, 5'b00000);
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (busy[0]) begin
        hit = 1'b1;
        break;
      end
      tick(1);
    end
    chk("atk start", 64'(hit), 64'd1);
    tick(20);
    chk("atk m20", 64'(get_lvl(0)), 64'd0);
    tick(40);
    chk("atk m60", 64'(get_lvl(0)), 64'd1);
    tick(360);
    chk("atk m420", 64'(get_lvl(0)), 64'd10);
    tick(1600);
    chk("atk m2020", 64'(get_lvl(0)), 64'd50);
    tick(3120);
    chk("atk peak", 64'(get_lvl(0)), 64'd128);
    chk("atk busy", 64'(busy[0]), 64'd1);
    tick(560);
    chk("dec m5700", 64'(get_lvl(0)), 64'd114);
    tick(560);
    chk("dec sl", 64'(get_lvl(0)), 64'd100);
    tick(740);
    chk("sus hold", 64'(get_lvl(0)), 64'd100);
    reg_sr[0 +: RW] = 8'd1;
    tick(2000);
    chk("sus m9000", 64'(get_lvl(0)), 64'd50);
    hit = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (!busy[0]) begin
        hit = 1'b1;
        break;
      end
      tick(1);
    end
    chk("sus idle", 64'(hit), 64'd1);
    chk("sus zero", 64'(get_lvl(0)), 64'd0);

    // pending latch while active is low
    reg_ar = '0;
    active = 1'b0;
    pulse(5'b01000, 5'b00000, 5'b00000);
    tick(10);
    chk("pend wait", 64'(busy[3]), 64'd0);
    active = 1'b1;
    tick(12);
    chk("pend env", 64'(get_lvl(3)), 64'd128);
    chk("pend busy", 64'(busy[3]), 64'd1);
    pulse(5'b00000, 5'b00000, 5'b01000);
    tick(12);

    // reset mid-attack on ch0/2/4
    reg_ar = {8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
    pulse(5'b10101, 5'b00000, 5'b00000);
    tick(200);
    chk("mid busy", 64'(busy), 64'b10101);
    chk("mid lvl", 64'(get_lvl(2) != 8'd0), 64'd1);
    active = 1'b0;
    pulse(5'b01000, 5'b00000, 5'b00000);
    nreset = 1'b0;
    #1;
    chk("rst env", 64'(envelope), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    @(negedge clk);
    nreset = 1'b1;
    active = 1'b1;
    reg_ar = '0;
    pulse(5'b00010, 5'b00000, 5'b00000);
    tick(1);
    chk("slot0 early", 64'(busy), 64'd0);
    tick(1);
    chk("slot0 busy", 64'(busy), 64'b00010);
    tick(10);
    chk("rst drop", 64'(busy), 64'b00010);
    chk("rst env1", 64'(envelope), 64'h0000008000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
